vga_pixel_prefetch: RTL and testbench

- Upstream pixel source for the 640x480 VGA timing stage.
- Fetches RGB pixels from a variable-latency framebuffer memory port ahead of the beam and buffers them in a first-word-fall-through FIFO.
- Presents one pixel per visible-area cycle to the colour outputs.
- Replaces the combinational pattern generator whenever framebuffer content is needed.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_pixel_prefetch_if.sv | 31 +++
 rtl/vga_pixel_fifo.sv | 68 ++++++
 rtl/vga_pixel_prefetch.sv | 126 ++++++++++++
 tb/tb_vga_pixel_prefetch.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the 640x480 pixel pipeline.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = 800;

  // Vertical timing, in lines
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = 525;

  localparam int unsigned COLOR_DEPTH = 4;

  // Packed pixel, red in the MSBs
  typedef struct packed {
    logic [COLOR_DEPTH-1:0] r;
    logic [COLOR_DEPTH-1:0] g;
    logic [COLOR_DEPTH-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/vga_pixel_prefetch_if.sv
// Framebuffer read port: request channel with ready/valid, in-order response channel.
interface vga_pixel_prefetch_if #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 12
);

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  // Pixel fetcher side
  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  // Framebuffer memory side
  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/vga_pixel_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush.
module vga_pixel_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy update; flush discards everything, including a same-cycle push
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// Prefetches framebuffer pixels ahead of the beam and presents one per visible cycle.
module vga_pixel_prefetch
  import vga_pkg::*;
#(
  parameter int unsigned VGA_WIDTH       = 640,
  parameter int unsigned VGA_HEIGHT      = 480,
  parameter int unsigned VGA_COLOR_DEPTH = 4,
  parameter int unsigned BUFFER_WIDTH    = VGA_COLOR_DEPTH * 3,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       pixel_req,
  output logic [VGA_COLOR_DEPTH-1:0] vga_r,
  output logic [VGA_COLOR_DEPTH-1:0] vga_g,
  output logic [VGA_COLOR_DEPTH-1:0] vga_b,
  output logic                       underflow,
  vga_pixel_prefetch_if.master       mem
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VGA_WIDTH * VGA_HEIGHT - 1);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic [CW-1:0]           discard_q, discard_d;
  logic                    underflow_q, underflow_d;

  logic                    req_valid, req_accept;
  logic                    rsp_drop, fifo_push, fifo_pop;
  logic [BUFFER_WIDTH-1:0] fifo_head, pixel_out;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty, fifo_full;
  logic [CW:0]             credit_used;

  vga_pixel_fifo #(
    .WIDTH (BUFFER_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (mem.mem_rsp_data),
    .pop_i   (fifo_pop),
    .flush_i (frame_start),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req_accept  = req_valid && mem.mem_req_ready;
  assign rsp_drop    = mem.mem_rsp_valid && (discard_q != '0);
  assign fifo_push   = mem.mem_rsp_valid && !rsp_drop;
  assign fifo_pop    = pixel_req && !fifo_empty;

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = addr_q;

  // Colour outputs: head falls through while requested, blanked otherwise
  assign pixel_out = fifo_pop ? fifo_head : '0;
  assign vga_r     = pixel_out[BUFFER_WIDTH-1 -: VGA_COLOR_DEPTH];
  assign vga_g     = pixel_out[2*VGA_COLOR_DEPTH-1 -: VGA_COLOR_DEPTH];
  assign vga_b     = pixel_out[VGA_COLOR_DEPTH-1:0];
  assign underflow = underflow_q;

  // Fetch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch next state: frame_start always (re)starts, last address accepted ends the frame
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = FETCH;
    end else if (state_q == FETCH && req_accept && addr_q == LAST_ADDR) begin
      state_d = DONE;
    end
  end

  // Request issue: only when every in-flight response is guaranteed a FIFO slot
  always_comb begin
    req_valid = (state_q == FETCH) && !fifo_full &&
                (credit_used < (CW+1)'(FIFO_DEPTH));
  end

  // Address, credit, discard and sticky underflow next-state
  always_comb begin
    addr_d        = addr_q;
    outstanding_d = outstanding_q + CW'(req_accept) - CW'(mem.mem_rsp_valid);
    discard_d     = discard_q;
    underflow_d   = underflow_q;
    if (frame_start) begin
      addr_d      = '0;
      // every request still in flight after this edge belongs to the old frame
      discard_d   = outstanding_d;
      underflow_d = 1'b0;
    end else begin
      if (req_accept && addr_q != LAST_ADDR) addr_d = addr_q + ADDR_WIDTH'(1);
      if (rsp_drop) discard_d = discard_q - CW'(1);
      if (pixel_req && fifo_empty) underflow_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      underflow_q   <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      underflow_q   <= underflow_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Self-checking bench: randomised memory latency/ready against a queue-based frame model.
module tb_vga_pixel_prefetch;

  localparam int unsigned W     = 640;
  localparam int unsigned H     = 4;
  localparam int unsigned CD    = 4;
  localparam int unsigned BW    = 12;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 19;
  localparam int unsigned LAST  = W * H - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic pixel_req = 1'b0;
  logic [CD-1:0] vga_r, vga_g, vga_b;
  logic underflow;

  vga_pixel_prefetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(BW)) mem_if ();

  vga_pixel_prefetch #(
    .VGA_WIDTH       (W),
    .VGA_HEIGHT      (H),
    .VGA_COLOR_DEPTH (CD),
    .BUFFER_WIDTH    (BW),
    .FIFO_DEPTH      (DEPTH),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pixel_req   (pixel_req),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .underflow   (underflow),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  // Memory transaction: data is fixed at accept time, epoch tags the frame it belongs to
  typedef struct {
    logic [BW-1:0] data;
    int unsigned   epoch;
    int unsigned   due;
  } txn_t;

  txn_t          pend[$];
  logic [BW-1:0] fifo_m[$];
  int unsigned   cyc, epoch, next_addr, lat, ready_pct, last_acc;
  logic [BW-1:0] key, last_rgb;
  bit            fetching, uf_m;
  int            checks, errors;

  task automatic model_reset();
    pend.delete();
    fifo_m.delete();
    uf_m      = 1'b0;
    fetching  = 1'b0;
    next_addr = 0;
    epoch     = epoch + 1;
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance the model, wait for next negedge
  task automatic step(input bit fs, input bit preq);
    logic [BW-1:0] exp_rgb, got_rgb;
    bit            exp_valid, acc;
    txn_t          t;
    frame_start = fs;
    pixel_req   = preq;
    mem_if.mem_req_ready = ($urandom_range(99) < ready_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_if.mem_rsp_valid = 1'b1;
      mem_if.mem_rsp_data  = pend[0].data;
    end else begin
      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_rsp_data  = BW'($urandom);
    end
    #1;
    got_rgb  = {vga_r, vga_g, vga_b};
    last_rgb = got_rgb;
    exp_rgb  = (preq && fifo_m.size() > 0) ? fifo_m[0] : '0;
    checks++;
    if (got_rgb !== exp_rgb) begin
      errors++;
      $display("FAIL rgb cyc=%0d got=%h exp=%h", cyc, got_rgb, exp_rgb);
    end
    checks++;
    if (underflow !== uf_m) begin
      errors++;
      $display("FAIL underflow cyc=%0d got=%b exp=%b", cyc, underflow, uf_m);
    end
    exp_valid = fetching && (fifo_m.size() + pend.size() < DEPTH);
    checks++;
    if (mem_if.mem_req_valid !== exp_valid) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, mem_if.mem_req_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (mem_if.mem_req_addr !== AW'(next_addr)) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%0d exp=%0d", cyc, mem_if.mem_req_addr, next_addr);
      end
    end
    checks++;
    if (dut.fifo_count > DEPTH || fifo_m.size() + pend.size() > DEPTH) begin
      errors++;
      $display("FAIL fifo_bound cyc=%0d got=%0d exp<=%0d", cyc, dut.fifo_count, DEPTH);
    end
    acc = (mem_if.mem_req_valid === 1'b1) && mem_if.mem_req_ready;
    // model advance for the coming edge
    if (preq) begin
      if (fifo_m.size() > 0) void'(fifo_m.pop_front());
      else uf_m = 1'b1;
    end
    if (mem_if.mem_rsp_valid) begin
      t = pend.pop_front();
      if (t.epoch == epoch) fifo_m.push_back(t.data);
    end
    if (acc) begin
      t.data  = mem_if.mem_req_addr[BW-1:0] ^ key;
      t.epoch = epoch;
      t.due   = cyc + lat;
      pend.push_back(t);
      last_acc = mem_if.mem_req_addr;
      if (next_addr == LAST) fetching = 1'b0;
      else next_addr++;
    end
    if (fs) begin
      fifo_m.delete();
      uf_m      = 1'b0;
      epoch     = epoch + 1;
      next_addr = 0;
      fetching  = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pixel_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({vga_r, vga_g, vga_b, underflow, mem_if.mem_req_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {vga_r, vga_g, vga_b, underflow, mem_if.mem_req_valid});
    end
    checks++;
    if (mem_if.mem_req_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr got=%0d exp=0", mem_if.mem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ready_pct = 100;
    lat = 1;
    repeat (5) step(1'b0, 1'b0);
  endtask

  task automatic test_stream();
    lat = 1; ready_pct = 100; key = '0;
    step(1'b1, 1'b0);
    repeat (19) step(1'b0, 1'b0);
    for (int i = 0; i < 640; i++) step(1'b0, 1'b1);
    checks++;
    if (last_rgb !== 12'h27F) begin
      errors++;
      $display("FAIL stream_pixel639 got=%h exp=27f", last_rgb);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_underflow got=%b exp=0", underflow);
    end
  endtask

  task automatic test_latency_random();
    lat = 8; ready_pct = 50; key = 12'h5A5;
    step(1'b1, 1'b0);
    for (int i = 0; i < 600; i++) step(1'b0, 1'($urandom_range(1)));
  endtask

  task automatic test_stall_underflow();
    ready_pct = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (last_rgb !== '0) begin
        errors++;
        $display("FAIL stall_rgb i=%0d got=%h exp=0", i, last_rgb);
      end
    end
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL stall_underflow_set got=%b exp=1", underflow);
    end
    step(1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL stall_underflow_clear got=%b exp=0", underflow);
    end
  endtask

  task automatic test_resync();
    int n;
    lat = 12; ready_pct = 100; key = 12'h111;
    step(1'b1, 1'b0);
    n = 0;
    while (next_addr != 5 && n < 40) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (next_addr != 5) begin
      errors++;
      $display("FAIL resync_timeout got=%0d exp=5", next_addr);
    end
    ready_pct = 0;
    step(1'b1, 1'b0);
    key = 12'h222; ready_pct = 100;
    repeat (30) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (last_rgb !== 12'h222) begin
      errors++;
      $display("FAIL resync_first_pixel got=%h exp=222", last_rgb);
    end
  endtask

  task automatic test_full_frame();
    int n;
    lat = 1; ready_pct = 100; key = '0;
    step(1'b1, 1'b0);
    n = 0;
    while (fetching && n < 4000) begin
      step(1'b0, 1'b1);
      n++;
    end
    checks++;
    if (fetching) begin
      errors++;
      $display("FAIL frame_timeout got=%0d exp=%0d", next_addr, LAST);
    end
    checks++;
    if (last_acc != LAST) begin
      errors++;
      $display("FAIL frame_last_addr got=%0d exp=%0d", last_acc, LAST);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (mem_if.mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_valid i=%0d got=%b exp=0", i, mem_if.mem_req_valid);
      end
    end
    step(1'b1, 1'b0);
    #1;
    checks++;
    if (mem_if.mem_req_valid !== 1'b1 || mem_if.mem_req_addr !== '0) begin
      errors++;
      $display("FAIL restart got=%b/%0d exp=1/0", mem_if.mem_req_valid, mem_if.mem_req_addr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_async_reset();
    lat = 2; ready_pct = 100; key = 12'h3C3;
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    pixel_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vga_r, vga_g, vga_b, underflow, mem_if.mem_req_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", {vga_r, vga_g, vga_b, underflow, mem_if.mem_req_valid});
    end
    mem_if.mem_rsp_valid = 1'b0;
    model_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (mem_if.mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_valid i=%0d got=%b exp=0", i, mem_if.mem_req_valid);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; epoch = 0; last_acc = 0;
    key = '0; last_rgb = '0; lat = 1; ready_pct = 0;
    fetching = 1'b0; uf_m = 1'b0; next_addr = 0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data  = '0;
    test_reset();
    test_stream();
    test_latency_random();
    test_stall_underflow();
    test_resync();
    test_full_frame();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
